// File: rtl/alu_arbiter.sv
// Two-requester ownership arbiter in front of a shared ALU: grants, muxes the owner's
// strobes to the ALU and returns its result view. Optional forced release: ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0,
    input  logic        i_req1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    input  logic [1:0]  i_op0,
    input  logic [1:0]  i_op1,
    input  logic        i_data_valid0,
    input  logic        i_data_valid1,
    input  logic [31:0] i_data0,
    input  logic [31:0] i_data1,
    input  logic [1:0]  i_out_op0,
    input  logic [1:0]  i_out_op1,
    input  logic        i_result_empty0,
    input  logic        i_result_empty1,
    output logic        o_result_valid0,
    output logic        o_result_valid1,
    output logic [31:0] o_result0,
    output logic [31:0] o_result1,
    output logic [4:0]  o_result_flags0,
    output logic [4:0]  o_result_flags1,
    output logic [1:0]  o_alu_input_op,
    output logic        o_alu_data_valid,
    output logic [31:0] o_alu_data,
    output logic [1:0]  o_alu_output_op,
    output logic        o_alu_result_empty,
    input  logic        i_alu_result_valid,
    input  logic [31:0] i_alu_result,
    input  logic [4:0]  i_alu_result_flags
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;   // 1: requester 1 was granted most recently
    logic   gnt0_q, gnt1_q;
    logic   timeout_c;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             other_req_c;

    // Counts owner cycles while the other requester is waiting.
    always_comb begin
        other_req_c = 1'b0;
        if (state_q == OWN0) other_req_c = i_req1;
        if (state_q == OWN1) other_req_c = i_req0;
        timeout_c = other_req_c && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d     = '0;
        if (other_req_c && (state_d == state_q)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    assign timeout_c = 1'b0;

    // Parameter kept so both builds share one interface.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    // Next-state arbitration.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE, DRAIN: begin
                state_d = IDLE;
                if (i_req0 && i_req1) state_d = last_q ? OWN0 : OWN1;
                else if (i_req0)      state_d = OWN0;
                else if (i_req1)      state_d = OWN1;
            end
            OWN0:    if (!i_req0 || timeout_c) state_d = DRAIN;
            OWN1:    if (!i_req1 || timeout_c) state_d = DRAIN;
            default: state_d = IDLE;
        endcase
        if ((state_d == OWN0) && (state_q != OWN0)) last_d = 1'b0;
        if ((state_d == OWN1) && (state_q != OWN1)) last_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt0_q  <= (state_d == OWN0);
            gnt1_q  <= (state_d == OWN1);
        end
    end

    assign o_gnt0 = gnt0_q;
    assign o_gnt1 = gnt1_q;

    // Zero-latency ALU mux; DRAIN only flushes a pending stale result.
    always_comb begin
        o_alu_input_op     = '0;
        o_alu_data_valid   = 1'b0;
        o_alu_data         = '0;
        o_alu_output_op    = '0;
        o_alu_result_empty = 1'b0;
        o_result_valid0    = 1'b0;
        o_result0          = '0;
        o_result_flags0    = '0;
        o_result_valid1    = 1'b0;
        o_result1          = '0;
        o_result_flags1    = '0;
        case (state_q)
            OWN0: begin
                o_alu_input_op     = i_op0;
                o_alu_data_valid   = i_data_valid0;
                o_alu_data         = i_data0;
                o_alu_output_op    = i_out_op0;
                o_alu_result_empty = i_result_empty0;
                o_result_valid0    = i_alu_result_valid;
                o_result0          = i_alu_result;
                o_result_flags0    = i_alu_result_flags;
            end
            OWN1: begin
                o_alu_input_op     = i_op1;
                o_alu_data_valid   = i_data_valid1;
                o_alu_data         = i_data1;
                o_alu_output_op    = i_out_op1;
                o_alu_result_empty = i_result_empty1;
                o_result_valid1    = i_alu_result_valid;
                o_result1          = i_alu_result;
                o_result_flags1    = i_alu_result_flags;
            end
            DRAIN:   o_alu_result_empty = i_alu_result_valid;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against an ownership model.
module tb_alu_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req [2];
    logic        gnt [2];
    logic [1:0]  op [2];
    logic        dv [2];
    logic [31:0] data [2];
    logic [1:0]  oop [2];
    logic        rempty [2];
    logic        rv [2];
    logic [31:0] res [2];
    logic [4:0]  rflags [2];
    logic [1:0]  alu_iop;
    logic        alu_dv;
    logic [31:0] alu_d;
    logic [1:0]  alu_oop;
    logic        alu_re;
    logic        alu_rv;
    logic [31:0] alu_res;
    logic [4:0]  alu_flags;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: who owns the ALU, whether a flush cycle is pending, who won last.
    int m_owner;
    int m_last;
    int m_tcnt;
    bit m_drain;

    always #5 clk = ~clk;

    alu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req[0]), .i_req1(req[1]),
        .o_gnt0(gnt[0]), .o_gnt1(gnt[1]),
        .i_op0(op[0]), .i_op1(op[1]),
        .i_data_valid0(dv[0]), .i_data_valid1(dv[1]),
        .i_data0(data[0]), .i_data1(data[1]),
        .i_out_op0(oop[0]), .i_out_op1(oop[1]),
        .i_result_empty0(rempty[0]), .i_result_empty1(rempty[1]),
        .o_result_valid0(rv[0]), .o_result_valid1(rv[1]),
        .o_result0(res[0]), .o_result1(res[1]),
        .o_result_flags0(rflags[0]), .o_result_flags1(rflags[1]),
        .o_alu_input_op(alu_iop), .o_alu_data_valid(alu_dv), .o_alu_data(alu_d),
        .o_alu_output_op(alu_oop), .o_alu_result_empty(alu_re),
        .i_alu_result_valid(alu_rv), .i_alu_result(alu_res), .i_alu_result_flags(alu_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_tcnt  = 0;
        m_drain = 1'b0;
    endtask

    task automatic check_outputs();
        logic [1:0]  e_iop, e_oop;
        logic        e_dv, e_re;
        logic [31:0] e_d;
        e_iop = '0; e_oop = '0; e_dv = 1'b0; e_re = 1'b0; e_d = '0;
        if (m_owner >= 0) begin
            e_iop = op[m_owner];
            e_dv  = dv[m_owner];
            e_d   = data[m_owner];
            e_oop = oop[m_owner];
            e_re  = rempty[m_owner];
        end else if (m_drain) begin
            e_re = alu_rv;
        end
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("gnt%0d", n), 32'(gnt[n]), 32'(m_owner == n));
            chk($sformatf("result_valid%0d", n), 32'(rv[n]), (m_owner == n) ? 32'(alu_rv) : 32'd0);
            chk($sformatf("result%0d", n), res[n], (m_owner == n) ? alu_res : 32'd0);
            chk($sformatf("result_flags%0d", n), 32'(rflags[n]), (m_owner == n) ? 32'(alu_flags) : 32'd0);
        end
        chk("alu_input_op", 32'(alu_iop), 32'(e_iop));
        chk("alu_data_valid", 32'(alu_dv), 32'(e_dv));
        chk("alu_data", alu_d, e_d);
        chk("alu_output_op", 32'(alu_oop), 32'(e_oop));
        chk("alu_result_empty", 32'(alu_re), 32'(e_re));
    endtask

    // Decide the next ownership from the inputs present at the coming edge, then take the edge.
    task automatic advance();
        int n_owner, n_last, n_tcnt;
        bit n_drain, leave;
        n_owner = m_owner; n_last = m_last; n_tcnt = m_tcnt; n_drain = m_drain; leave = 1'b0;
        if (m_owner >= 0) begin
            leave = !req[m_owner];
`ifdef ALU_ARB_TIMEOUT_EN
            if (!leave && req[1-m_owner]) begin
                n_tcnt = m_tcnt + 1;
                if (n_tcnt >= int'(TO)) leave = 1'b1;
            end else begin
                n_tcnt = 0;
            end
`endif
            if (leave) begin
                n_owner = -1; n_drain = 1'b1; n_tcnt = 0;
            end
        end else begin
            n_drain = 1'b0;
            if (req[0] && req[1]) n_owner = 1 - m_last;
            else if (req[0])      n_owner = 0;
            else if (req[1])      n_owner = 1;
            else                  n_owner = -1;
            if (n_owner >= 0) begin
                n_last = n_owner; n_tcnt = 0;
            end
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_owner = n_owner; m_last = n_last; m_tcnt = n_tcnt; m_drain = n_drain;
        end else begin
            model_reset();
        end
    endtask

    task automatic step();
        #2;
        if (!rst_n) model_reset();
        check_outputs();
        advance();
    endtask

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            req[n] = 1'b0; op[n] = '0; dv[n] = 1'b0; data[n] = '0;
            oop[n] = '0; rempty[n] = 1'b0;
        end
        alu_rv = 1'b0; alu_res = '0; alu_flags = '0;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        step();
        step();

        // Reset release with a simultaneous tie: requester 0 wins.
        rst_n = 1'b1; req[0] = 1'b1; req[1] = 1'b1;
        step();
        chk("tie_first_gnt0", 32'(gnt[0]), 32'd1);
        chk("tie_first_gnt1", 32'(gnt[1]), 32'd0);

        // Owner strobes forwarded at once; non-owner strobes ignored.
        dv[0] = 1'b1; data[0] = 32'h0000_0005; op[0] = 2'd2;
        dv[1] = 1'b1; data[1] = 32'hdead_beef; op[1] = 2'd1;
        #2;
        chk("fwd_data_valid", 32'(alu_dv), 32'd1);
        chk("fwd_data", alu_d, 32'h5);
        chk("fwd_input_op", 32'(alu_iop), 32'd2);
        check_outputs();
        advance();

        // Owner drops with a stale result pending: one flush cycle, then handover.
        alu_rv = 1'b1; alu_res = 32'h1234_5678; alu_flags = 5'h15;
        req[0] = 1'b0; req[1] = 1'b1;
        step();
        #2;
        chk("drain_result_empty", 32'(alu_re), 32'd1);
        chk("drain_output_op", 32'(alu_oop), 32'd0);
        chk("drain_result_valid1", 32'(rv[1]), 32'd0);
        chk("drain_gnt0", 32'(gnt[0]), 32'd0);
        chk("drain_gnt1", 32'(gnt[1]), 32'd0);
        check_outputs();
        advance();
        alu_rv = 1'b0;
        #2;
        chk("handover_gnt1", 32'(gnt[1]), 32'd1);
        chk("handover_result_valid1", 32'(rv[1]), 32'd0);
        check_outputs();

        // Asynchronous reset in the middle of ownership.
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt1", 32'(gnt[1]), 32'd0);
        chk("async_rst_data_valid", 32'(alu_dv), 32'd0);
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        clear_inputs();
        step();
        rst_n = 1'b1;
        step();

        // Contention renewed per transaction: grants alternate.
        for (int t = 0; t < 4; t++) begin
            req[0] = 1'b1; req[1] = 1'b1;
            step();
            chk($sformatf("alt%0d_gnt0", t), 32'(gnt[0]), 32'((t % 2) == 0));
            chk($sformatf("alt%0d_gnt1", t), 32'(gnt[1]), 32'((t % 2) == 1));
            req[0] = 1'b0; req[1] = 1'b0;
            step();
            step();
        end

        // Both requests held: forced release only with the timeout build.
        req[0] = 1'b1; req[1] = 1'b1;
        step();
        cnt = 0;
        for (int i = 0; i < 120; i++) begin
            if (gnt[0] !== 1'b1) break;
            cnt++;
            step();
        end
`ifdef ALU_ARB_TIMEOUT_EN
        chk("timeout_hold_cycles", 32'(cnt), 32'(TO));
        chk("timeout_drain_gnt1", 32'(gnt[1]), 32'd0);
        step();
        chk("timeout_next_gnt1", 32'(gnt[1]), 32'd1);
`else
        chk("hold_cycles", 32'(cnt), 32'd120);
        chk("hold_gnt1", 32'(gnt[1]), 32'd0);
`endif
        req[0] = 1'b0; req[1] = 1'b0;
        step();
        step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(63) != 0);
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(3) == 0) req[n] = ~req[n];
                op[n]     = 2'($urandom_range(3));
                dv[n]     = 1'($urandom_range(1));
                data[n]   = $urandom;
                oop[n]    = 2'($urandom_range(3));
                rempty[n] = 1'($urandom_range(1));
            end
            alu_rv    = 1'($urandom_range(1));
            alu_res   = $urandom;
            alu_flags = 5'($urandom_range(31));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, meaning: grant cycles before forced release while the other requester waits (used only with ALU_ARB_TIMEOUT_EN).
REQ-002 i_clk  input  1  clock; all state changes on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_reqN (N=0,1)  input  1  requester N asks for ALU ownership.
REQ-005 o_gntN  output  1  requester N owns the ALU (registered).
REQ-006 i_opN  input  2  requester N ALU input op.
REQ-007 i_data_validN  input  1  requester N operand strobe.
REQ-008 i_dataN  input  32  requester N operand.
REQ-009 i_out_opN  input  2  requester N ALU output op.
REQ-010 i_result_emptyN  input  1  requester N result-consume strobe.
REQ-011 o_result_validN, o_resultN, o_result_flagsN  output  1/32/5  ALU result view for requester N.
REQ-012 o_alu_input_op, o_alu_data_valid, o_alu_data, o_alu_output_op, o_alu_result_empty  output  2/1/32/2/1  ALU drive.
REQ-013 i_alu_result_valid, i_alu_result, i_alu_result_flags  input  1/32/5  ALU result.

Function
REQ-014 FSM states IDLE, OWN0, OWN1, DRAIN; o_gnt0=1 only in OWN0, o_gnt1=1 only in OWN1.
REQ-015 IDLE/DRAIN exit: single req -> OWN of that requester; both -> OWN of requester not last granted; none -> IDLE.
REQ-016 Grant latency: req sampled high at edge k (arbiter in IDLE) -> o_gnt high after edge k.
REQ-017 OWNn: stay while i_reqn=1; i_reqn=0 sampled -> DRAIN next cycle.
REQ-018 DRAIN lasts exactly one cycle; if i_alu_result_valid=1 then o_alu_result_empty=1, o_alu_output_op=0 that cycle (stale result flushed); otherwise ALU outputs 0.
REQ-019 Last-granted pointer updates on every entry to OWN0/OWN1.
REQ-020 In OWNn, o_alu_* equal requester n inputs combinationally (zero latency); in IDLE/DRAIN (except REQ-018) all o_alu_* are 0.
REQ-021 Non-owner inputs ignored entirely; non-owner o_result_valid=0, o_result=0, o_result_flags=0.
REQ-022 Owner o_result_valid/o_result/o_result_flags = i_alu_result_valid/i_alu_result/i_alu_result_flags.
REQ-023 Owner strobes in the cycle i_req falls are still forwarded (gnt still high).
REQ-024 Both gnts never high simultaneously, including across reset.

Reset
REQ-025 i_rst_n low: state IDLE, o_gnt0=o_gnt1=0, all o_alu_* 0, all o_result* 0, last-granted=1 (requester 0 wins first tie), timeout counter 0; takes effect immediately, without a clock.
REQ-026 Reset mid-ownership drops gnt immediately; no DRAIN performed; the first edge after deassertion arbitrates from IDLE.

Configuration
REQ-027 Macro ALU_ARB_TIMEOUT_EN defined: counter increments each OWNn cycle where the other req=1, clears on leaving OWNn or other req=0; on reaching TIMEOUT_CYCLES forces DRAIN although owner req=1; the owner then competes with lower priority.
REQ-028 ALU_ARB_TIMEOUT_EN undefined: no counter, ownership held indefinitely, TIMEOUT_CYCLES unused.

Verification
REQ-029 Reset release, i_req0=i_req1=1 same edge -> o_gnt0=1 next cycle, o_gnt1=0.
REQ-030 OWN0, i_data_valid0=1, i_data0=0x0000_0005, i_op0=2 -> o_alu_data_valid=1, o_alu_data=0x5, o_alu_input_op=2 same cycle; i_data_valid1=1 concurrently -> not forwarded.
REQ-031 OWN0 with i_alu_result_valid=1, i_req0 drops, i_req1=1 -> one DRAIN cycle with o_alu_result_empty=1, then o_gnt1=1; o_result_valid1 stays 0 throughout.
REQ-032 Alternating contention (both reqs toggled per transaction) -> grants strictly alternate 0,1,0,1.
REQ-033 ALU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, both reqs held -> o_gnt0 for 4 cycles, 1 DRAIN, o_gnt1; without macro o_gnt0 held for 100+ cycles.
REQ-034 i_rst_n pulsed low mid-OWN1 -> o_gnt1=0 asynchronously, o_alu_data_valid=0, no clock edge needed.
